pwm_channels: RTL and testbench
===============================

# pwm_channels

Command-driven bank of NPWM hardware PWM channels. It is the PWM unit behind the command dispatcher. It accepts decoded config and schedule commands over the shared unit argument interface and applies each new duty value at a requested systime. An optional watchdog reverts a channel to a default duty when it is not refreshed in time. It sends no responses and never requests involuntary transmission.

## Interface
- NPWM, 12, number of PWM channels (1..16)
- CMD_CONFIG_PWM, 3, command id of config_pwm
- CMD_SCHEDULE_PWM, 4, command id of schedule_pwm
- clk  in  1  system clock; one clock domain for everything
- rst_n  in  1  reset, asynchronous, active-low
- systime  in  64  global time in clk ticks; only [31:0] is used
- cmd  in  4  command id, valid while cmd_ready is high
- cmd_ready  in  1  one-cycle pulse: command dispatched to this unit
- arg_data  in  32  current argument; holds arg 0 when cmd_ready pulses
- arg_advance  out  1  one-cycle pulse requesting the next argument
- cmd_done  out  1  one-cycle pulse: command fully consumed
- param_data  out  32  always 0
- param_write  out  1  always 0
- invol_req  out  1  always 0
- invol_grant  in  1  ignored
- pwm  out  NPWM  registered PWM outputs

## Operation
- Per-channel registers, 32 bits each: cycle_ticks, on_ticks, default_ticks, max_duration, dur_left, pend_clock, pend_ticks. Each channel also has a pend_valid flag and a free-running counter cnt.
- Argument fetch:
  - Read arg_data, pulse arg_advance, skip one cycle, then read the next argument.
  - Every argument after arg 0 therefore costs 2 cycles.
  - Do not pulse arg_advance after the last argument.
- config_pwm arguments are: channel, cycle_ticks, on_ticks, default_ticks, max_duration. Its effect:
  - Load all four registers and set cnt to 0.
  - Clear pend_valid.
  - Set dur_left to max_duration.
- schedule_pwm arguments are: channel, clock, on_ticks. Its effect:
  - Set pend_clock and pend_ticks.
  - Set pend_valid. A later schedule overwrites a pending one.
- Channel index ≥ NPWM: read all remaining arguments, change no state, then pulse cmd_done.
- Any other cmd id: pulse cmd_done on the cycle after cmd_ready and read no arguments.
- Command FSM states:
  - IDLE → (cmd_ready) ARG
  - ARG → WAIT (after arg_advance) → ARG … → EXEC
  - EXEC applies the command and pulses cmd_done → IDLE
- Schedule apply:
  - Condition: pend_valid and $signed(systime[31:0] − pend_clock) ≥ 0. This is a 32-bit wrap-safe compare, so a clock already in the past applies immediately.
  - Action: on_ticks ← pend_ticks, clear pend_valid, dur_left ← max_duration.
- Watchdog:
  - Runs when max_duration ≠ 0 and on_ticks ≠ default_ticks.
  - dur_left decrements every clk.
  - When it reaches 0, on_ticks ← default_ticks.
- Counter: cnt increments every clk and wraps to 0 when cnt = cycle_ticks − 1.
- Output:
  - pwm[i] ← (cycle_ticks ≠ 0) && (cnt < on_ticks).
  - on_ticks ≥ cycle_ticks gives a constant high output.
  - cycle_ticks = 0 gives a constant low output.
- All arithmetic is 32-bit unsigned unless stated. Channels run independently in parallel.

## Timing
- Reset values: pwm, arg_advance, cmd_done, param_* and invol_req are 0; all channel registers are 0; the FSM is in IDLE.
- Asserting rst_n low mid-command aborts the command immediately. cmd_done is not pulsed.
- Command latency from cmd_ready to cmd_done:
  - config_pwm: 2×4 + 2 = 10 cycles.
  - schedule_pwm: 2×2 + 2 = 6 cycles.
- cmd_ready while busy is ignored. The dispatcher never issues it while busy.
- A schedule applies on the first clk edge where the compare holds. pwm reflects the new on_ticks one cycle later.
- Apply and watchdog expiry in the same cycle: the apply wins.
- A config for a channel in the same cycle as that channel's apply: the config wins.

## Test plan
- Basic PWM: config ch0 with cycle 10, on 3, default 0, maxdur 0. Expect pwm[0] high 3 cycles, low 7, with period 10. Expect cmd_done 10 cycles after cmd_ready.
- Scheduled change: config ch1 with cycle 8, on 0. Then schedule ch1 at clock = systime+100 with on 8. Expect pwm[1] low until systime+100, then constantly high from the next cycle.
- Wrap and past time: systime[31:0] = 0xFFFFFFF0, schedule clock 0x00000010. Expect the apply 32 cycles later. A clock 5 ticks in the past applies immediately.
- Watchdog: config ch2 with cycle 4, on 4, default 0, maxdur 50. Expect pwm[2] high for about 50 cycles, then low. Rescheduling on 4 before expiry keeps it high.
- Invalid channel and unknown command: schedule ch 15 with NPWM = 12 gives no output change and cmd_done after 6 cycles. cmd = 9 gives cmd_done on the next cycle with no arg_advance.
- Reset mid-command: drop rst_n during argument fetch. Expect all pwm = 0 and no cmd_done. The next command completes normally.

Source files
------------

// File: rtl/pwm_channels.sv
// pwm_channels: command-driven bank of NPWM PWM channels with time-scheduled
// duty updates and an optional per-channel watchdog that reverts to a default duty.
module pwm_channels #(
    parameter int          NPWM             = 12,
    parameter logic [3:0]  CMD_CONFIG_PWM   = 4'd3,
    parameter logic [3:0]  CMD_SCHEDULE_PWM = 4'd4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [63:0]     systime,
    input  logic [3:0]      cmd,
    input  logic            cmd_ready,
    input  logic [31:0]     arg_data,
    output logic            arg_advance,
    output logic            cmd_done,
    output logic [31:0]     param_data,
    output logic            param_write,
    output logic            invol_req,
    input  logic            invol_grant,
    output logic [NPWM-1:0] pwm
);

    typedef enum logic [1:0] {IDLE, ARG, WAIT, EXEC} state_t;

    state_t      state, state_next;
    logic        adv_next, done_next;
    logic        exec_cfg, exec_sch;
    logic [3:0]  cur_cmd;
    logic [2:0]  arg_idx, last_idx;
    logic [31:0] args [5];

    logic [31:0] cycle_ticks   [NPWM];
    logic [31:0] on_ticks      [NPWM];
    logic [31:0] default_ticks [NPWM];
    logic [31:0] max_duration  [NPWM];
    logic [31:0] dur_left      [NPWM];
    logic [31:0] pend_clock    [NPWM];
    logic [31:0] pend_ticks    [NPWM];
    logic [31:0] cnt           [NPWM];
    logic [NPWM-1:0] pend_valid, apply_due, wd_run;

    logic unused_inputs;

    assign param_data    = '0;
    assign param_write   = 1'b0;
    assign invol_req     = 1'b0;
    assign unused_inputs = ^{systime[63:32], invol_grant};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            arg_advance <= 1'b0;
            cmd_done    <= 1'b0;
        end else begin
            state       <= state_next;
            arg_advance <= adv_next;
            cmd_done    <= done_next;
        end
    end

    // Each argument after the first costs an advance pulse plus one skipped cycle.
    always_comb begin
        state_next = state;
        adv_next   = 1'b0;
        done_next  = 1'b0;
        exec_cfg   = 1'b0;
        exec_sch   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_ready) begin
                    if (cmd == CMD_CONFIG_PWM || cmd == CMD_SCHEDULE_PWM) begin
                        state_next = WAIT;
                        adv_next   = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                    end
                end
            end
            WAIT: state_next = ARG;
            ARG: begin
                if (arg_idx == last_idx) begin
                    state_next = EXEC;
                end else begin
                    state_next = WAIT;
                    adv_next   = 1'b1;
                end
            end
            EXEC: begin
                state_next = IDLE;
                done_next  = 1'b1;
                exec_cfg   = (cur_cmd == CMD_CONFIG_PWM);
                exec_sch   = (cur_cmd == CMD_SCHEDULE_PWM);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_cmd  <= '0;
            arg_idx  <= '0;
            last_idx <= '0;
            for (int j = 0; j < 5; j++) args[j] <= '0;
        end else if (state == IDLE && cmd_ready) begin
            cur_cmd  <= cmd;
            args[0]  <= arg_data;
            arg_idx  <= 3'd1;
            last_idx <= (cmd == CMD_CONFIG_PWM) ? 3'd4 : 3'd2;
        end else if (state == ARG) begin
            args[arg_idx] <= arg_data;
            arg_idx       <= arg_idx + 3'd1;
        end
    end

    // Wrap-safe "systime has reached pend_clock": difference within the lower half.
    always_comb begin
        for (int i = 0; i < NPWM; i++) begin
            apply_due[i] = pend_valid[i] && ((systime[31:0] - pend_clock[i]) < 32'h8000_0000);
            wd_run[i]    = (max_duration[i] != '0) && (on_ticks[i] != default_ticks[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm        <= '0;
            pend_valid <= '0;
            for (int i = 0; i < NPWM; i++) begin
                cycle_ticks[i]   <= '0;
                on_ticks[i]      <= '0;
                default_ticks[i] <= '0;
                max_duration[i]  <= '0;
                dur_left[i]      <= '0;
                pend_clock[i]    <= '0;
                pend_ticks[i]    <= '0;
                cnt[i]           <= '0;
            end
        end else begin
            for (int i = 0; i < NPWM; i++) begin
                pwm[i] <= (cycle_ticks[i] != '0) && (cnt[i] < on_ticks[i]);
                cnt[i] <= (cnt[i] == cycle_ticks[i] - 32'd1) ? 32'd0 : cnt[i] + 32'd1;

                if (apply_due[i]) begin
                    on_ticks[i]   <= pend_ticks[i];
                    pend_valid[i] <= 1'b0;
                    dur_left[i]   <= max_duration[i];
                end else if (wd_run[i]) begin
                    if (dur_left[i] <= 32'd1) begin
                        dur_left[i] <= '0;
                        on_ticks[i] <= default_ticks[i];
                    end else begin
                        dur_left[i] <= dur_left[i] - 32'd1;
                    end
                end

                // Command writes come last so a config overrides a same-cycle apply.
                if (exec_cfg && args[0] == 32'(i)) begin
                    cycle_ticks[i]   <= args[1];
                    on_ticks[i]      <= args[2];
                    default_ticks[i] <= args[3];
                    max_duration[i]  <= args[4];
                    dur_left[i]      <= args[4];
                    cnt[i]           <= '0;
                    pend_valid[i]    <= 1'b0;
                end
                if (exec_sch && args[0] == 32'(i)) begin
                    pend_clock[i] <= args[1];
                    pend_ticks[i] <= args[2];
                    pend_valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_channels.sv
// tb_pwm_channels: randomized and directed stimulus for pwm_channels, checked
// against a behavioural channel model kept in the bench.
module tb_pwm_channels;

    localparam int NPWM = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [63:0]     systime;
    logic [3:0]      cmd;
    logic            cmd_ready;
    logic [31:0]     arg_data;
    logic            arg_advance;
    logic            cmd_done;
    logic [31:0]     param_data;
    logic            param_write;
    logic            invol_req;
    logic            invol_grant;
    logic [NPWM-1:0] pwm;

    logic [63:0] tick = '0;
    logic [63:0] sys_offset;
    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_cycle [NPWM], m_on [NPWM], m_def [NPWM], m_maxd [NPWM];
    logic [31:0] m_dur [NPWM], m_cnt [NPWM], m_pclk [NPWM], m_pticks [NPWM];
    logic [NPWM-1:0] m_pend;
    logic [NPWM-1:0] pwm_exp;
    longint mcyc = 0;
    longint mc_cyc = -1;
    logic [3:0]  mc_cmd;
    logic [31:0] mc_args [5];

    pwm_channels dut (
        .clk(clk), .rst_n(rst_n), .systime(systime), .cmd(cmd), .cmd_ready(cmd_ready),
        .arg_data(arg_data), .arg_advance(arg_advance), .cmd_done(cmd_done),
        .param_data(param_data), .param_write(param_write), .invol_req(invol_req),
        .invol_grant(invol_grant), .pwm(pwm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 64'd1;
    assign systime = sys_offset + tick;

    // Channel rules evaluated once per clock edge; commands land on their spec-derived edge.
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] d;
        if (!rst_n) begin
            pwm_exp = '0;
            m_pend  = '0;
            for (int i = 0; i < NPWM; i++) begin
                m_cycle[i] = 0; m_on[i] = 0; m_def[i] = 0; m_maxd[i] = 0;
                m_dur[i] = 0; m_cnt[i] = 0; m_pclk[i] = 0; m_pticks[i] = 0;
            end
        end else begin
            mcyc = mcyc + 1;
            for (int i = 0; i < NPWM; i++) begin
                pwm_exp[i] = (m_cycle[i] != 0) && (m_cnt[i] < m_on[i]);
                m_cnt[i] = (m_cycle[i] == 0) ? m_cnt[i] + 1 : (m_cnt[i] + 1) % m_cycle[i];
                d = systime[31:0] - m_pclk[i];
                if (m_pend[i] && $signed(d) >= 0) begin
                    m_on[i] = m_pticks[i];
                    m_pend[i] = 1'b0;
                    m_dur[i] = m_maxd[i];
                end else if (m_maxd[i] != 0 && m_on[i] != m_def[i]) begin
                    m_dur[i] = m_dur[i] - 1;
                    if (m_dur[i] == 0) m_on[i] = m_def[i];
                end
                if (mcyc == mc_cyc && mc_args[0] == 32'(i)) begin
                    if (mc_cmd == 4'd3) begin
                        m_cycle[i] = mc_args[1]; m_on[i] = mc_args[2]; m_def[i] = mc_args[3];
                        m_maxd[i] = mc_args[4]; m_dur[i] = mc_args[4];
                        m_cnt[i] = 0; m_pend[i] = 1'b0;
                    end else begin
                        m_pclk[i] = mc_args[1]; m_pticks[i] = mc_args[2]; m_pend[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Dispatcher: presents arg 0 with cmd_ready, then the next argument one cycle after each advance.
    task automatic send_cmd(input logic [3:0] c, input logic [31:0] a0, a1, a2, a3, a4,
                            output int lat, output int advs);
        logic [31:0] args [5];
        int nargs, idx;
        bit adv_seen;
        nargs = (c == 4'd3) ? 5 : (c == 4'd4) ? 3 : 1;
        args[0] = a0; args[1] = a1; args[2] = a2; args[3] = a3; args[4] = a4;
        for (int j = nargs; j < 5; j++) args[j] = 32'hDEAD_BEEF;
        @(negedge clk);
        if (c == 4'd3 || c == 4'd4) begin
            mc_cmd = c;
            for (int j = 0; j < 5; j++) mc_args[j] = args[j];
            mc_cyc = mcyc + ((c == 4'd3) ? 10 : 6);
        end
        cmd = c; cmd_ready = 1'b1; arg_data = args[0];
        idx = 0; adv_seen = 1'b0; lat = -1; advs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cmd_ready = 1'b0;
            if (adv_seen) begin
                idx++;
                arg_data = (idx < 5) ? args[idx] : 32'hDEAD_BEEF;
            end
            adv_seen = arg_advance;
            if (arg_advance) advs++;
            if (cmd_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (pwm !== '0) begin miscompares++; $display("[TB] FAIL reset_pwm: got %h, expected 0", pwm); end
        vectors++; if (arg_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_arg_advance: got %b, expected 0", arg_advance); end
        vectors++; if (cmd_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_done: got %b, expected 0", cmd_done); end
        vectors++; if (param_data !== '0) begin miscompares++; $display("[TB] FAIL reset_param_data: got %h, expected 0", param_data); end
        vectors++; if (param_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_param_write: got %b, expected 0", param_write); end
        vectors++; if (invol_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_invol_req: got %b, expected 0", invol_req); end
    endtask

    task automatic test_basic_pwm();
        int lat, advs, highs;
        send_cmd(4'd3, 0, 10, 3, 0, 0, lat, advs);
        vectors++; if (lat !== 10) begin miscompares++; $display("[TB] FAIL config_latency: got %0d, expected 10", lat); end
        vectors++; if (advs !== 4) begin miscompares++; $display("[TB] FAIL config_advances: got %0d, expected 4", advs); end
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL basic_pwm: got %h, expected %h", pwm, pwm_exp); end
            if (k >= 10 && k < 20 && pwm[0]) highs++;
        end
        vectors++; if (highs !== 3) begin miscompares++; $display("[TB] FAIL basic_duty: got %0d high of 10, expected 3", highs); end
    endtask

    task automatic test_scheduled();
        int lat, advs;
        bit rise_seen;
        logic [31:0] t_sched, rise_time;
        send_cmd(4'd3, 1, 8, 0, 0, 0, lat, advs);
        t_sched = systime[31:0] + 32'd100;
        send_cmd(4'd4, 1, t_sched, 8, 0, 0, lat, advs);
        vectors++; if (lat !== 6) begin miscompares++; $display("[TB] FAIL schedule_latency: got %0d, expected 6", lat); end
        vectors++; if (advs !== 2) begin miscompares++; $display("[TB] FAIL schedule_advances: got %0d, expected 2", advs); end
        rise_seen = 1'b0; rise_time = '0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL sched_pwm: got %h, expected %h", pwm, pwm_exp); end
            if (!rise_seen && pwm[1]) begin rise_seen = 1'b1; rise_time = systime[31:0]; end
        end
        vectors++; if (!rise_seen || rise_time !== t_sched + 32'd2) begin
            miscompares++; $display("[TB] FAIL sched_rise_time: got %h (seen=%0d), expected %h", rise_time, rise_seen, t_sched + 32'd2);
        end
    endtask

    task automatic test_wrap_past();
        int lat, advs, waited;
        bit rise_seen;
        logic [31:0] rise_time;
        send_cmd(4'd3, 1, 8, 0, 0, 0, lat, advs);
        sys_offset = 64'h0000_0007_FFFF_FFF0 - tick;
        send_cmd(4'd4, 1, 32'h0000_0010, 8, 0, 0, lat, advs);
        rise_seen = 1'b0; rise_time = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL wrap_pwm: got %h, expected %h", pwm, pwm_exp); end
            if (!rise_seen && pwm[1]) begin rise_seen = 1'b1; rise_time = systime[31:0]; end
        end
        vectors++; if (!rise_seen || rise_time !== 32'h0000_0012) begin
            miscompares++; $display("[TB] FAIL wrap_rise_time: got %h (seen=%0d), expected 00000012", rise_time, rise_seen);
        end
        send_cmd(4'd3, 1, 8, 0, 0, 0, lat, advs);
        send_cmd(4'd4, 1, systime[31:0] - 32'd5, 8, 0, 0, lat, advs);
        waited = 0;
        while (!pwm[1] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++; if (waited !== 2) begin miscompares++; $display("[TB] FAIL past_apply_delay: got %0d cycles, expected 2", waited); end
    endtask

    task automatic test_watchdog();
        int lat, advs, highs, lows;
        send_cmd(4'd3, 2, 4, 4, 0, 50, lat, advs);
        highs = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL wd_pwm: got %h, expected %h", pwm, pwm_exp); end
            if (pwm[2]) highs++;
        end
        vectors++; if (highs !== 50) begin miscompares++; $display("[TB] FAIL wd_high_cycles: got %0d, expected 50", highs); end
        send_cmd(4'd3, 2, 4, 4, 0, 50, lat, advs);
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!pwm[2]) lows++;
        end
        send_cmd(4'd4, 2, systime[31:0] - 32'd1, 4, 0, 0, lat, advs);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL wd_refresh_pwm: got %h, expected %h", pwm, pwm_exp); end
            if (!pwm[2]) lows++;
        end
        vectors++; if (lows !== 0) begin miscompares++; $display("[TB] FAIL wd_refresh_kept_high: got %0d low cycles, expected 0", lows); end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL wd_expire_pwm: got %h, expected %h", pwm, pwm_exp); end
        end
    endtask

    task automatic test_invalid();
        int lat, advs;
        send_cmd(4'd4, 15, systime[31:0] - 32'd5, 5, 0, 0, lat, advs);
        vectors++; if (lat !== 6) begin miscompares++; $display("[TB] FAIL invalid_ch_latency: got %0d, expected 6", lat); end
        vectors++; if (advs !== 2) begin miscompares++; $display("[TB] FAIL invalid_ch_advances: got %0d, expected 2", advs); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL invalid_ch_pwm: got %h, expected %h", pwm, pwm_exp); end
        end
        send_cmd(4'd9, 1, 0, 0, 0, 0, lat, advs);
        vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL unknown_cmd_latency: got %0d, expected 1", lat); end
        vectors++; if (advs !== 0) begin miscompares++; $display("[TB] FAIL unknown_cmd_advances: got %0d, expected 0", advs); end
    endtask

    task automatic test_random();
        int lat, advs, exp_lat, run;
        logic [31:0] ch;
        for (int n = 0; n < 30; n++) begin
            ch = 32'($urandom_range(0, 13));
            if ($urandom_range(0, 1) == 1) begin
                send_cmd(4'd3, ch, 32'($urandom_range(0, 16)), 32'($urandom_range(0, 18)),
                         32'($urandom_range(0, 18)),
                         ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(5, 40)), lat, advs);
                exp_lat = 10;
            end else begin
                send_cmd(4'd4, ch, systime[31:0] + 32'($urandom_range(0, 40)) - 32'd10,
                         32'($urandom_range(0, 18)), 0, 0, lat, advs);
                exp_lat = 6;
            end
            vectors++; if (lat !== exp_lat) begin miscompares++; $display("[TB] FAIL rand_latency: got %0d, expected %0d", lat, exp_lat); end
            run = $urandom_range(5, 40);
            for (int k = 0; k < run; k++) begin
                @(negedge clk);
                vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL rand_pwm: got %h, expected %h", pwm, pwm_exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, advs;
        send_cmd(4'd3, 4, 4, 4, 0, 0, lat, advs);
        repeat (3) @(negedge clk);
        vectors++; if (pwm[4] !== 1'b1) begin miscompares++; $display("[TB] FAIL premid_pwm4: got %b, expected 1", pwm[4]); end
        @(negedge clk);
        cmd = 4'd3; cmd_ready = 1'b1; arg_data = 32'd3;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        arg_data = 32'd5;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (pwm !== '0) begin miscompares++; $display("[TB] FAIL midreset_pwm: got %h, expected 0", pwm); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            vectors++; if (cmd_done !== 1'b0 || pwm !== pwm_exp) begin
                miscompares++; $display("[TB] FAIL after_abort: cmd_done=%b pwm=%h, expected 0 and %h", cmd_done, pwm, pwm_exp);
            end
        end
        send_cmd(4'd3, 3, 5, 2, 0, 0, lat, advs);
        vectors++; if (lat !== 10) begin miscompares++; $display("[TB] FAIL post_abort_latency: got %0d, expected 10", lat); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++; if (pwm !== pwm_exp) begin miscompares++; $display("[TB] FAIL post_abort_pwm: got %h, expected %h", pwm, pwm_exp); end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd = '0; cmd_ready = 1'b0; arg_data = '0;
        invol_grant = 1'b0; sys_offset = 64'h1000;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic_pwm();
        test_scheduled();
        test_wrap_past();
        test_watchdog();
        test_invalid();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
